cr_osf_ob_gate: RTL and testbench
=================================

Name: cr_osf_ob_gate

Overview:
- Outbound stage directly downstream of the output stream formatter (OSF).
- Consumes the OSF outbound AXI4-stream and hands it to the engine output port through a 2-entry skid buffer.
- Enforces supervisor halt only at frame boundaries.
- Produces per-beat byte and per-frame statistics strobes, and polices frame length against a configured limit.

Parameters:
- BUF_DEPTH, 2, skid buffer entries; fixed at 2, other values unsupported.
- BEAT_CNT_W, 16, width of the per-frame beat counter.

Ports:
- clk  input  1  core clock.
- rst_n  input  1  asynchronous active-low reset.
- ob_in  input  axi4s_dp_bus_t  stream from OSF (fields pvalid, tlast, tid, tstrb[7:0], tuser, tdata[63:0]).
- ob_in_rdy  output  axi4s_dp_rdy_t  ready back to OSF.
- ob_out  output  axi4s_dp_bus_t  stream to engine output.
- ob_out_rdy  input  axi4s_dp_rdy_t  downstream ready.
- sup_halt  input  1  supervisor halt request.
- cfg_max_beats  input  BEAT_CNT_W  maximum beats per frame; 0 disables the check.
- err_clr  input  1  clears the sticky length error.
- gate_halted  output  1  halt in effect and buffer empty.
- ob_bytes_cnt_stb  output  1  output beat transferred.
- ob_bytes_cnt_amt  output  4  valid bytes in the transferred beat.
- ob_frame_cnt_stb  output  1  output tlast transferred.
- frame_len_err  output  1  sticky frame length violation.

Behaviour:
- Reset values:
  - ob_in_rdy = 0; ob_out.pvalid = 0; all other ob_out fields = 0.
  - All strobes = 0; frame_len_err = 0; gate_halted = 0.
  - Buffer count = 0; beat counter = 0; FSM = IDLE.
- Transfers:
  - Input transfer = ob_in.pvalid & ob_in_rdy.
  - Output transfer = ob_out.pvalid & ob_out_rdy.
- Skid buffer:
  - 2-entry FIFO registered on both sides.
  - ob_in_rdy is a registered signal: asserted when the next-cycle count is < 2 and the FSM permits acceptance.
  - ob_out is driven from the head entry register.
  - Latency is 1 cycle from input transfer to ob_out.pvalid when the buffer is empty.
  - Simultaneous push and pop keeps the count unchanged.
  - Full throughput of 1 beat/cycle is sustained with ob_out_rdy held high.
  - No combinational path from ob_out_rdy to ob_in_rdy.
- FSM (input side):
  - IDLE (between frames):
    - input transfer with tlast=0 -> IN_FRAME;
    - input transfer with tlast=1 -> stay IDLE;
    - sup_halt=1 and no transfer -> HALTED.
  - IN_FRAME: input transfer with tlast=1 -> HALTED if sup_halt=1, else IDLE.
  - HALTED: ob_in_rdy forced 0; sup_halt=0 -> IDLE.
  - sup_halt never splits a frame. A halt asserted mid-frame is honoured after that frame's tlast is accepted.
  - If halt is deasserted before tlast, no halt occurs.
- gate_halted = (state==HALTED) & (count==0), registered.
  - The output side keeps draining while HALTED.
- Statistics (output side, registered, 1-cycle pulse, cycle after output transfer):
  - ob_bytes_cnt_stb on every output transfer.
  - ob_bytes_cnt_amt = popcount(tstrb), range 0..8.
  - tstrb = 0 gives amt = 0 with the stb still asserted.
  - ob_frame_cnt_stb when the transferred beat has tlast=1.
- Length check (input side):
  - Beat counter increments per input transfer and saturates at all-ones.
  - Counter resets to 0 on the cycle after a tlast transfer.
  - If cfg_max_beats != 0 and a transfer makes the beat count exceed cfg_max_beats, frame_len_err is set.
  - Data still passes unmodified.
  - frame_len_err is cleared by err_clr. If set and clear occur in the same cycle, set wins.
- Reset mid-frame: buffer contents discarded, FSM = IDLE, no strobes emitted.
- tid, tuser and tdata pass through unchanged. Beat order is preserved.

Decomposition:
- cr_osfPKG holds:
  - the FSM state enum (IDLE, IN_FRAME, HALTED);
  - the constant OB_GATE_BUF_DEPTH = 2;
  - a popcount8 function returning 4 bits.
- axi4s_dp_bus_t and axi4s_dp_rdy_t come from cr_structs.
- One sub-module: cr_osf_ob_skid, the 2-entry registered buffer with count and registered ready. The FSM, statistics and length check remain in the top.

Test Plan:
- Single 4-beat frame, tstrb = FF,FF,FF,0F, ob_out_rdy = 1 -> 4 beats out in order starting 1 cycle after the first accept; amt = 8,8,8,4; one ob_frame_cnt_stb aligned with the last beat.
- Streaming 100 single-beat frames, ob_out_rdy = 1 -> 100 beats in 100 consecutive cycles; 100 frame strobes.
- Backpressure: ob_out_rdy random at 30% -> no beat lost or duplicated; ob_in_rdy falls within 1 cycle of count reaching 2.
- sup_halt asserted at beat 2 of an 8-beat frame -> beats 3-8 are still accepted; ob_in_rdy = 0 after tlast; gate_halted = 1 once drained; halt release resumes the next frame.
- cfg_max_beats = 3 with a 5-beat frame -> frame_len_err set on the 4th accepted beat; all 5 beats delivered; err_clr releases it; simultaneous set and clear keeps it at 1.
- rst_n asserted with 2 beats buffered mid-frame -> all outputs return to reset values; after reset, a new frame passes and its first beat count starts at 1.

Source files
------------

// File: rtl/cr_osf_ob_gate_pkg.sv
// Shared stream types plus the outbound-gate package: FSM states, buffer depth
// and the tstrb popcount helper.
package cr_structs;
  typedef struct packed {
    logic        pvalid;
    logic        tlast;
    logic [3:0]  tid;
    logic [7:0]  tstrb;
    logic [7:0]  tuser;
    logic [63:0] tdata;
  } axi4s_dp_bus_t;

  typedef logic axi4s_dp_rdy_t;
endpackage

package cr_osfPKG;
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    IN_FRAME = 2'd1,
    HALTED   = 2'd2
  } ob_gate_state_e;

  localparam int OB_GATE_BUF_DEPTH = 2;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < 8; i++) c = c + {3'b000, v[i]};
    return c;
  endfunction
endpackage

// File: rtl/cr_osf_ob_gate_if.sv
// One stream hop: bus travels master->slave, rdy travels slave->master.
// A beat transfers on a clock edge where bus.pvalid and rdy are both 1.
interface cr_osf_ob_gate_if;
  import cr_structs::*;

  axi4s_dp_bus_t bus;
  axi4s_dp_rdy_t rdy;

  modport master (output bus, input rdy);
  modport slave  (input bus, output rdy);
endinterface

// File: rtl/cr_osf_ob_gate_skid.sv
// Two-entry skid buffer, registered on both sides: head register drives the
// downstream bus and upstream ready is a flop predicted from next occupancy.
module cr_osf_ob_skid
  import cr_structs::*;
#(
  parameter int BUF_DEPTH = cr_osfPKG::OB_GATE_BUF_DEPTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    accept_en,
  cr_osf_ob_gate_if.slave         up,
  cr_osf_ob_gate_if.master        dn,
  output logic [1:0]              cnt,
  output logic                    push,
  output logic                    pop
);
  localparam logic [1:0] FULL = 2'(BUF_DEPTH);

  axi4s_dp_bus_t head_q, tail_q;
  logic [1:0]    cnt_q, cnt_nxt;
  logic          rdy_q;

  assign push = up.bus.pvalid & rdy_q;
  assign pop  = (cnt_q != 2'd0) & dn.rdy;
  assign cnt  = cnt_q;
  assign up.rdy = rdy_q;

  always_comb begin
    dn.bus        = head_q;
    dn.bus.pvalid = (cnt_q != 2'd0);
  end

  always_comb begin
    cnt_nxt = cnt_q;
    case ({push, pop})
      2'b10:   cnt_nxt = cnt_q + 2'd1;
      2'b01:   cnt_nxt = cnt_q - 2'd1;
      default: cnt_nxt = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= 2'd0;
      rdy_q  <= 1'b0;
      head_q <= '0;
      tail_q <= '0;
    end else begin
      cnt_q <= cnt_nxt;
      // Ready depends only on registered state and the predicted count, so
      // downstream ready never reaches upstream ready combinationally.
      rdy_q <= (cnt_nxt < FULL) & accept_en;
      if (push) begin
        if (cnt_q == 2'd0 || (cnt_q == 2'd1 && pop)) head_q <= up.bus;
        else                                         tail_q <= up.bus;
      end
      if (pop && cnt_q == 2'd2) head_q <= tail_q;
    end
  end
endmodule

// File: rtl/cr_osf_ob_gate.sv
// Outbound gate after the OSF: frame-boundary halt, output statistics strobes
// and frame-length policing around a 2-entry skid buffer.
module cr_osf_ob_gate
  import cr_structs::*, cr_osfPKG::*;
#(
  parameter int BUF_DEPTH  = 2,
  parameter int BEAT_CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  axi4s_dp_bus_t         ob_in,
  output axi4s_dp_rdy_t         ob_in_rdy,
  output axi4s_dp_bus_t         ob_out,
  input  axi4s_dp_rdy_t         ob_out_rdy,
  input  logic                  sup_halt,
  input  logic [BEAT_CNT_W-1:0] cfg_max_beats,
  input  logic                  err_clr,
  output logic                  gate_halted,
  output logic                  ob_bytes_cnt_stb,
  output logic [3:0]            ob_bytes_cnt_amt,
  output logic                  ob_frame_cnt_stb,
  output logic                  frame_len_err
);
  cr_osf_ob_gate_if up_if ();
  cr_osf_ob_gate_if dn_if ();

  assign up_if.bus = ob_in;
  assign ob_in_rdy = up_if.rdy;
  assign ob_out    = dn_if.bus;
  assign dn_if.rdy = ob_out_rdy;

  ob_gate_state_e        state_q, state_nxt;
  logic                  push, pop, accept_en;
  logic [1:0]            cnt;
  logic [BEAT_CNT_W-1:0] beat_q, beat_inc;
  logic                  len_viol;

  cr_osf_ob_skid #(.BUF_DEPTH(BUF_DEPTH)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .accept_en (accept_en),
    .up        (up_if.slave),
    .dn        (dn_if.master),
    .cnt       (cnt),
    .push      (push),
    .pop       (pop)
  );

  // Halt is only taken between frames; mid-frame it waits for tlast.
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      IDLE: begin
        if (push)          state_nxt = ob_in.tlast ? IDLE : IN_FRAME;
        else if (sup_halt) state_nxt = HALTED;
      end
      IN_FRAME: begin
        if (push && ob_in.tlast) state_nxt = sup_halt ? HALTED : IDLE;
      end
      HALTED: begin
        if (!sup_halt) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign accept_en = (state_nxt != HALTED);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      gate_halted <= 1'b0;
    end else begin
      state_q     <= state_nxt;
      gate_halted <= (state_q == HALTED) && (cnt == 2'd0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ob_bytes_cnt_stb <= 1'b0;
      ob_bytes_cnt_amt <= 4'd0;
      ob_frame_cnt_stb <= 1'b0;
    end else begin
      ob_bytes_cnt_stb <= pop;
      ob_bytes_cnt_amt <= pop ? popcount8(ob_out.tstrb) : 4'd0;
      ob_frame_cnt_stb <= pop & ob_out.tlast;
    end
  end

  // beat_inc is the position of the beat being accepted this cycle (1-based).
  assign beat_inc = (&beat_q) ? beat_q : beat_q + 1'b1;
  assign len_viol = push && (cfg_max_beats != '0) && (beat_inc > cfg_max_beats);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_q        <= '0;
      frame_len_err <= 1'b0;
    end else begin
      if (push) beat_q <= ob_in.tlast ? '0 : beat_inc;
      if (len_viol)     frame_len_err <= 1'b1;
      else if (err_clr) frame_len_err <= 1'b0;
    end
  end
endmodule

// File: tb/tb_cr_osf_ob_gate.sv
// Directed-sequence bench with randomized beat contents, checked against a
// queue-based model of the outbound gate.
module tb_cr_osf_ob_gate;
  import cr_structs::*;

  localparam int W = $bits(axi4s_dp_bus_t);

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cr_osf_ob_gate_if in_if ();
  cr_osf_ob_gate_if out_if ();

  logic        sup_halt = 1'b0;
  logic        err_clr = 1'b0;
  logic [15:0] cfg_max_beats = 16'd0;
  logic        gate_halted, bytes_stb, frame_stb, frame_len_err;
  logic [3:0]  bytes_amt;

  cr_osf_ob_gate #(.BUF_DEPTH(2), .BEAT_CNT_W(16)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .ob_in            (in_if.bus),
    .ob_in_rdy        (in_if.rdy),
    .ob_out           (out_if.bus),
    .ob_out_rdy       (out_if.rdy),
    .sup_halt         (sup_halt),
    .cfg_max_beats    (cfg_max_beats),
    .err_clr          (err_clr),
    .gate_halted      (gate_halted),
    .ob_bytes_cnt_stb (bytes_stb),
    .ob_bytes_cnt_amt (bytes_amt),
    .ob_frame_cnt_stb (frame_stb),
    .frame_len_err    (frame_len_err)
  );

  // scoreboard / model state
  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  int   fb = 0;
  logic exp_err = 1'b0, exp_bstb = 1'b0, exp_fstb = 1'b0;
  logic [3:0] exp_amt = 4'd0;
  bit   in_reset = 1'b1;
  bit   in_xfer_s = 1'b0;
  int   cyc = 0, rdy_pct = 100;
  int   out_cnt = 0, fstb_cnt = 0, first_out = -1, last_out = -1, first_in = -1;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    logic out_x, in_x, set;
    axi4s_dp_bus_t b;
    if (in_reset) return;
    chk("out_pvalid", out_if.bus.pvalid, exp_q.size() != 0);
    chk("bytes_stb", bytes_stb, exp_bstb);
    chk("bytes_amt", bytes_amt, exp_amt);
    chk("frame_stb", frame_stb, exp_fstb);
    chk("len_err", frame_len_err, exp_err);
    if (exp_q.size() >= 2) chk("in_rdy_full", in_if.rdy, 1'b0);
    if (frame_stb === 1'b1) fstb_cnt++;
    out_x = out_if.bus.pvalid & out_if.rdy;
    in_x  = in_if.bus.pvalid & in_if.rdy;
    exp_bstb = 1'b0; exp_fstb = 1'b0; exp_amt = 4'd0;
    if (out_x) begin
      if (exp_q.size() == 0) chk("out_spurious", 1'b1, 1'b0);
      else begin
        b = axi4s_dp_bus_t'(exp_q.pop_front());
        chk("out_beat", out_if.bus, b);
        exp_bstb = 1'b1;
        exp_amt  = 4'($countones(b.tstrb));
        exp_fstb = b.tlast;
        out_cnt++;
        if (first_out < 0) first_out = cyc;
        last_out = cyc;
      end
    end
    set = in_x && (cfg_max_beats != 0) && (fb + 1 > int'(cfg_max_beats));
    exp_err = set ? 1'b1 : (err_clr ? 1'b0 : exp_err);
    if (in_x) begin
      exp_q.push_back(in_if.bus);
      fb = in_if.bus.tlast ? 0 : fb + 1;
      if (first_in < 0) first_in = cyc;
    end
    in_xfer_s = in_x;
  endtask

  // driver tasks
  task automatic tick();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
    cyc++;
    out_if.rdy = ($urandom_range(0, 99) < rdy_pct);
  endtask

  task automatic set_beat(input logic last, input logic [7:0] strb);
    in_if.bus.pvalid = 1'b1;
    in_if.bus.tlast  = last;
    in_if.bus.tid    = 4'($urandom);
    in_if.bus.tuser  = 8'($urandom);
    in_if.bus.tstrb  = strb;
    in_if.bus.tdata  = {$urandom, $urandom};
  endtask

  task automatic send_beat(input logic last, input logic [7:0] strb);
    int n;
    set_beat(last, strb);
    n = 0;
    do begin tick(); n++; end while (!in_xfer_s && n < 200);
    chk("accept_timeout", in_xfer_s, 1'b1);
  endtask

  task automatic idle();
    in_if.bus.pvalid = 1'b0;
  endtask

  task automatic drain(input int limit);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < limit) begin tick(); n++; end
    chk("drain_timeout", exp_q.size(), 0);
    tick();
    tick();
  endtask

  task automatic clear_counts();
    out_cnt = 0; fstb_cnt = 0; first_out = -1; last_out = -1; first_in = -1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_rdy"}, in_if.rdy, 1'b0);
    chk({tag, "_out_bus"}, out_if.bus, '0);
    chk({tag, "_bstb"}, bytes_stb, 1'b0);
    chk({tag, "_amt"}, bytes_amt, 4'd0);
    chk({tag, "_fstb"}, frame_stb, 1'b0);
    chk({tag, "_err"}, frame_len_err, 1'b0);
    chk({tag, "_halted"}, gate_halted, 1'b0);
  endtask

  initial begin
    int n, len, sent;
    in_if.bus = '0;
    out_if.rdy = 1'b1;
    #2;
    check_reset_outputs("rst0");
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    in_reset = 1'b0;
    tick(); tick();

    // 4-beat frame, full downstream ready
    clear_counts();
    send_beat(1'b0, 8'hFF); send_beat(1'b0, 8'hFF); send_beat(1'b0, 8'hFF);
    send_beat(1'b1, 8'h0F);
    idle();
    drain(50);
    chk("t1_beats", out_cnt, 4);
    chk("t1_frames", fstb_cnt, 1);
    chk("t1_latency", first_out - first_in, 1);

    // 100 back-to-back single-beat frames
    clear_counts();
    for (int i = 0; i < 100; i++) send_beat(1'b1, (i % 10 == 0) ? 8'h00 : 8'($urandom));
    idle();
    drain(50);
    chk("t2_beats", out_cnt, 100);
    chk("t2_frames", fstb_cnt, 100);
    chk("t2_span", last_out - first_out, 99);

    // random backpressure at 30% ready
    clear_counts();
    rdy_pct = 30;
    sent = 0;
    for (int f = 0; f < 5; f++) begin
      len = $urandom_range(1, 6);
      for (int b = 0; b < len; b++) begin
        send_beat(b == len - 1, 8'($urandom_range(0, 255)));
        sent++;
      end
    end
    idle();
    drain(1000);
    chk("t3_beats", out_cnt, sent);
    rdy_pct = 100;
    out_if.rdy = 1'b1;

    // halt raised at beat 2 of an 8-beat frame
    send_beat(1'b0, 8'hFF); send_beat(1'b0, 8'hFF);
    sup_halt = 1'b1;
    for (int b = 2; b < 8; b++) send_beat(b == 7, 8'hFF);
    idle();
    tick();
    chk("t4_rdy_after_tlast", in_if.rdy, 1'b0);
    n = 0;
    while (gate_halted !== 1'b1 && n < 20) begin tick(); n++; end
    chk("t4_gate_halted", gate_halted, 1'b1);
    chk("t4_drained", exp_q.size(), 0);
    set_beat(1'b1, 8'h3C);
    for (int k = 0; k < 5; k++) begin tick(); chk("t4_blocked", in_xfer_s, 1'b0); end
    sup_halt = 1'b0;
    n = 0;
    do begin tick(); n++; end while (!in_xfer_s && n < 20);
    chk("t4_resume", in_xfer_s, 1'b1);
    idle();
    drain(50);
    chk("t4_gate_released", gate_halted, 1'b0);

    // frame length limit 3 with a 5-beat frame
    cfg_max_beats = 16'd3;
    for (int b = 0; b < 5; b++) send_beat(b == 4, 8'($urandom));
    idle();
    drain(50);
    chk("t5_err_set", frame_len_err, 1'b1);
    err_clr = 1'b1; tick(); err_clr = 1'b0; tick();
    chk("t5_err_clr", frame_len_err, 1'b0);
    err_clr = 1'b1;
    for (int b = 0; b < 5; b++) send_beat(b == 4, 8'($urandom));
    err_clr = 1'b0;
    idle();
    drain(50);
    chk("t5_set_wins", frame_len_err, 1'b1);
    err_clr = 1'b1; tick(); err_clr = 1'b0; tick();
    chk("t5_err_clr2", frame_len_err, 1'b0);
    cfg_max_beats = 16'd0;

    // reset with two beats buffered mid-frame
    rdy_pct = 0;
    out_if.rdy = 1'b0;
    send_beat(1'b0, 8'hFF); send_beat(1'b0, 8'h01);
    idle();
    tick();
    chk("t6_full_rdy", in_if.rdy, 1'b0);
    rst_n = 1'b0;
    in_reset = 1'b1;
    #1;
    check_reset_outputs("t6_rst");
    exp_q.delete();
    fb = 0; exp_err = 1'b0; exp_bstb = 1'b0; exp_fstb = 1'b0; exp_amt = 4'd0;
    @(posedge clk); @(posedge clk); #1;
    rdy_pct = 100;
    out_if.rdy = 1'b1;
    rst_n = 1'b1;
    in_reset = 1'b0;
    clear_counts();
    cfg_max_beats = 16'd1;
    tick();
    send_beat(1'b0, 8'hFF);
    chk("t6_first_beat_ok", frame_len_err, 1'b0);
    send_beat(1'b0, 8'hFF); send_beat(1'b1, 8'hFF);
    idle();
    drain(50);
    chk("t6_err", frame_len_err, 1'b1);
    chk("t6_beats", out_cnt, 3);

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
